// File: rtl/fpu_defs.sv
// Shared FPU definitions: rounding-mode encodings and the normaliser stage-1 payload.
package fpu_defs;

  localparam logic [2:0] C_FPU_RM_RNE = 3'b000;
  localparam logic [2:0] C_FPU_RM_RTZ = 3'b001;
  localparam logic [2:0] C_FPU_RM_RDN = 3'b010;
  localparam logic [2:0] C_FPU_RM_RUP = 3'b011;
  localparam logic [2:0] C_FPU_RM_RMM = 3'b100;

  // Width-independent part of the stage-1 register; mantissa/exponent are held
  // alongside it because their widths follow the module parameters.
  typedef struct packed {
    logic       sign;
    logic [2:0] rm;
    logic       subn;
    logic       guard;
    logic       rnd;
    logic       sticky;
  } fpu_norm_s1_t;

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; cnt = WIDTH when the input is all zero.
module fpu_lzc #(
  parameter int WIDTH = 48,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Ascending scan: the highest set bit is the last writer.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (data[i]) cnt = CNT_W'(WIDTH - 1 - i);
  end

  assign zero = ~|data;

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage normaliser/rounder (LZC+shift, then round+flags) with valid/ready and flush.
// FPU_NORM_SUBNORM_EN enables gradual underflow; otherwise tiny results flush to zero.
module fpu_norm_pipe
  import fpu_defs::*;
#(
  parameter int EXP_WIDTH         = 8,
  parameter int MANT_WIDTH        = 23,
  parameter int PRENORM_WIDTH     = 48,
  parameter int EXP_PRENORM_WIDTH = EXP_WIDTH + 2
) (
  input  logic                                Clk_CI,
  input  logic                                Rst_RI,
  input  logic                                Flush_SI,
  input  logic                                In_valid_SI,
  output logic                                In_ready_SO,
  input  logic [PRENORM_WIDTH-1:0]            Mant_in_DI,
  input  logic signed [EXP_PRENORM_WIDTH-1:0] Exp_in_DI,
  input  logic                                Sign_in_DI,
  input  logic [2:0]                          RM_SI,
  output logic                                Out_valid_SO,
  input  logic                                Out_ready_SI,
  output logic [MANT_WIDTH:0]                 Mant_res_DO,
  output logic [EXP_WIDTH-1:0]                Exp_res_DO,
  output logic                                Sign_res_DO,
  output logic                                Inexact_SO,
  output logic                                Exp_OF_SO,
  output logic                                Exp_UF_SO,
  output logic                                Zero_SO
);

  localparam int W   = PRENORM_WIDTH;
  localparam int MW  = MANT_WIDTH + 1;
  localparam int EW  = EXP_PRENORM_WIDTH + 1;
  localparam int LZW = $clog2(W + 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_WIDTH) - 1);
`ifdef FPU_NORM_SUBNORM_EN
  localparam bit SUBNORM_EN = 1'b1;
`else
  localparam bit SUBNORM_EN = 1'b0;
`endif

  logic s1_valid, s2_valid, s2_adv, in_fire;
  assign s2_adv       = ~s2_valid | Out_ready_SI;
  assign In_ready_SO  = ~s1_valid | s2_adv;
  assign in_fire      = In_valid_SI & In_ready_SO;
  assign Out_valid_SO = s2_valid;

  // ---------------- stage 1: LZC / shift ----------------
  logic [LZW-1:0]       lzc;
  logic                 mant_zero, subn_d;
  logic signed [EW-1:0] exp_in_x, lzc_x, exp_norm_d;
  logic [2*W-1:0]       ext, shifted;

  fpu_lzc #(.WIDTH(W), .CNT_W(LZW)) u_lzc (.data(Mant_in_DI), .cnt(lzc), .zero(mant_zero));

  assign exp_in_x = EW'(Exp_in_DI);
  assign lzc_x    = {{(EW-LZW){1'b0}}, lzc};
  // Zero-padded below so a right shift up to W loses nothing before sticky is taken.
  assign ext      = {Mant_in_DI, {W{1'b0}}};

`ifdef FPU_NORM_SUBNORM_EN
  logic [EW-1:0] rsh;
  assign subn_d = mant_zero | (lzc_x >= exp_in_x);
  always_comb begin
    shifted    = ext << lzc;
    exp_norm_d = exp_in_x - lzc_x + EW'(1);
    rsh        = -exp_in_x;
    if (subn_d) begin
      exp_norm_d = '0;
      if (exp_in_x[EW-1]) shifted = ext >> ((rsh > EW'(W)) ? EW'(W) : rsh);
      else                shifted = ext << exp_in_x;
    end
  end
`else
  always_comb begin
    shifted    = ext << lzc;
    exp_norm_d = exp_in_x - lzc_x + EW'(1);
    subn_d     = mant_zero | exp_norm_d[EW-1] | (exp_norm_d == '0);
  end
`endif

  fpu_norm_s1_t         s1_q;
  logic [MW-1:0]        s1_mant;
  logic signed [EW-1:0] s1_exp;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_mant  <= '0;
      s1_exp   <= '0;
    end else begin
      if (Flush_SI)         s1_valid <= 1'b0;
      else if (In_ready_SO) s1_valid <= In_valid_SI;
      if (in_fire) begin
        s1_mant <= shifted[2*W-1 -: MW];
        s1_exp  <= exp_norm_d;
        s1_q    <= '{sign: Sign_in_DI, rm: RM_SI, subn: subn_d,
                     guard: shifted[2*W-MW-1], rnd: shifted[2*W-MW-2],
                     sticky: |shifted[2*W-MW-3:0]};
      end
    end
  end

  // ---------------- stage 2: round / flags ----------------
  logic                 rup, inexact, ovf, to_inf;
  logic [MW:0]          sum;
  logic [MW-1:0]        mant_r, mant_d;
  logic signed [EW-1:0] exp_base, exp_r;
  logic [EXP_WIDTH-1:0] exp_d;
  logic                 nx_d, of_d, uf_d, zero_d;

  always_comb begin
    inexact = s1_q.guard | s1_q.rnd | s1_q.sticky;
    case (s1_q.rm)
      C_FPU_RM_RNE: rup = s1_q.guard & (s1_q.rnd | s1_q.sticky | s1_mant[0]);
      C_FPU_RM_RMM: rup = s1_q.guard;
      C_FPU_RM_RUP: rup = inexact & ~s1_q.sign;
      C_FPU_RM_RDN: rup = inexact & s1_q.sign;
      default:      rup = 1'b0;
    endcase
    sum = {1'b0, s1_mant} + {{MW{1'b0}}, rup};
    // A subnormal whose hidden bit ends up set (already, or by rounding) is exponent 1.
    exp_base = s1_q.subn ? EW'(1) : s1_exp;
    if (sum[MW]) begin
      mant_r = sum[MW:1];
      exp_r  = exp_base + EW'(1);
    end else begin
      mant_r = sum[MW-1:0];
      exp_r  = (s1_q.subn & ~sum[MW-1]) ? '0 : exp_base;
    end
    ovf    = exp_r >= EXP_MAX;
    to_inf = (s1_q.rm == C_FPU_RM_RNE) | (s1_q.rm == C_FPU_RM_RMM) |
             ((s1_q.rm == C_FPU_RM_RUP) & ~s1_q.sign) | ((s1_q.rm == C_FPU_RM_RDN) & s1_q.sign);

    mant_d = mant_r;
    exp_d  = exp_r[EXP_WIDTH-1:0];
    nx_d   = inexact;
    of_d   = 1'b0;
    if (ovf) begin
      of_d = 1'b1;
      nx_d = 1'b1;
      if (to_inf) begin
        exp_d  = '1;
        mant_d = '0;
      end else begin
        exp_d  = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
        mant_d = '1;
      end
    end
    // Flush-to-zero: a normalised nonzero input always has its top bit set here.
    if (!SUBNORM_EN && s1_q.subn) begin
      mant_d = '0;
      exp_d  = '0;
      nx_d   = s1_mant[MW-1];
    end
    uf_d   = (exp_d == '0) & nx_d;
    zero_d = (mant_d == '0) & (exp_d == '0);
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      s2_valid    <= 1'b0;
      Mant_res_DO <= '0;
      Exp_res_DO  <= '0;
      Sign_res_DO <= 1'b0;
      Inexact_SO  <= 1'b0;
      Exp_OF_SO   <= 1'b0;
      Exp_UF_SO   <= 1'b0;
      Zero_SO     <= 1'b0;
    end else begin
      if (Flush_SI)    s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv & s1_valid) begin
        Mant_res_DO <= mant_d;
        Exp_res_DO  <= exp_d;
        Sign_res_DO <= s1_q.sign;
        Inexact_SO  <= nx_d;
        Exp_OF_SO   <= of_d;
        Exp_UF_SO   <= uf_d;
        Zero_SO     <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Directed bench for fpu_norm_pipe (default 8/23/48); honours FPU_NORM_SUBNORM_EN.
module tb_fpu_norm_pipe;
  import fpu_defs::*;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, sign_in;
  logic              out_valid, out_ready, sign_res, nx, of, uf, zr;
  logic [47:0]       mant_in;
  logic signed [9:0] exp_in;
  logic [2:0]        rm;
  logic [23:0]       mant_res;
  logic [7:0]        exp_res;
  int                n_cmp = 0;
  int                n_bad = 0;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic [3:0]  flg;   // {inexact, overflow, underflow, zero}
  } res_t;
  res_t outq[$];

  always #5 clk = ~clk;

  fpu_norm_pipe dut (
    .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush),
    .In_valid_SI(in_valid), .In_ready_SO(in_ready),
    .Mant_in_DI(mant_in), .Exp_in_DI(exp_in), .Sign_in_DI(sign_in), .RM_SI(rm),
    .Out_valid_SO(out_valid), .Out_ready_SI(out_ready),
    .Mant_res_DO(mant_res), .Exp_res_DO(exp_res), .Sign_res_DO(sign_res),
    .Inexact_SO(nx), .Exp_OF_SO(of), .Exp_UF_SO(uf), .Zero_SO(zr)
  );

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      outq.push_back(res_t'({mant_res, exp_res, sign_res, nx, of, uf, zr}));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Entered and left at posedge+1; returns right after the accepting edge.
  task automatic send(input logic [47:0] m, input logic signed [9:0] e, input logic s,
                      input logic [2:0] r);
    int t;
    mant_in = m; exp_in = e; sign_in = s; rm = r; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("accept", 48'(in_ready), 48'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_res(input string tag, output res_t r);
    int t;
    t = 0;
    while (outq.size() == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_avail"}, 48'(outq.size() != 0), 48'd1);
    r = '0;
    if (outq.size() != 0) r = outq.pop_front();
  endtask

  task automatic op(input string tag, input logic [47:0] m, input logic signed [9:0] e,
                    input logic s, input logic [2:0] r,
                    input logic [23:0] wm, input logic [7:0] we, input logic [3:0] wf);
    res_t q;
    send(m, e, s, r);
    get_res(tag, q);
    chk({tag, "_mant"},  48'(q.mant), 48'(wm));
    chk({tag, "_exp"},   48'(q.exp),  48'(we));
    chk({tag, "_flags"}, 48'(q.flg),  48'(wf));
    chk({tag, "_sign"},  48'(q.sign), 48'(s));
    @(posedge clk); #1;
  endtask

  initial begin
    res_t q;
    logic seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mant_in = '0; exp_in = '0;
    sign_in = 1'b0; rm = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 48'(out_valid), 48'd0);
    chk("rst_mant",  48'(mant_res),  48'd0);
    chk("rst_exp",   48'(exp_res),   48'd0);
    chk("rst_flags", 48'({nx, of, uf, zr, sign_res}), 48'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 48'(in_ready), 48'd1);

    // Exact normal with latency check
    send(48'h4000_0000_0000, 10'sd127, 1'b0, C_FPU_RM_RNE);
    @(negedge clk); chk("lat_c1", 48'(out_valid), 48'd0);
    @(negedge clk); chk("lat_c2", 48'(out_valid), 48'd1);
    get_res("exact", q);
    chk("exact_mant",  48'(q.mant), 48'h80_0000);
    chk("exact_exp",   48'(q.exp),  48'd127);
    chk("exact_flags", 48'(q.flg),  48'd0);
    @(posedge clk); #1;

    op("carry",   48'h8000_0000_0000, 10'sd127, 1'b0, C_FPU_RM_RNE, 24'h800000, 8'd128, 4'b0000);
    op("tie_rne", 48'h4000_0040_0000, 10'sd127, 1'b0, C_FPU_RM_RNE, 24'h800000, 8'd127, 4'b1000);
    op("tie_rmm", 48'h4000_0040_0000, 10'sd127, 1'b0, C_FPU_RM_RMM, 24'h800001, 8'd127, 4'b1000);
    op("tie_odd", 48'h4000_00C0_0000, 10'sd127, 1'b0, C_FPU_RM_RNE, 24'h800002, 8'd127, 4'b1000);
    op("rup_pos", 48'h4000_0040_0000, 10'sd127, 1'b0, C_FPU_RM_RUP, 24'h800001, 8'd127, 4'b1000);
    op("rup_neg", 48'h4000_0040_0000, 10'sd127, 1'b1, C_FPU_RM_RUP, 24'h800000, 8'd127, 4'b1000);
    op("rdn_neg", 48'h4000_0040_0000, 10'sd127, 1'b1, C_FPU_RM_RDN, 24'h800001, 8'd127, 4'b1000);
    op("of_rne",  48'hFFFF_FFFF_FFFF, 10'sd254, 1'b0, C_FPU_RM_RNE, 24'h000000, 8'd255, 4'b1100);
    op("of_rtz",  48'hFFFF_FFFF_FFFF, 10'sd254, 1'b0, C_FPU_RM_RTZ, 24'hFFFFFF, 8'd254, 4'b1100);
    op("of_rdnp", 48'hFFFF_FFFF_FFFF, 10'sd254, 1'b0, C_FPU_RM_RDN, 24'hFFFFFF, 8'd254, 4'b1100);
    op("of_rdnn", 48'hFFFF_FFFF_FFFF, 10'sd254, 1'b1, C_FPU_RM_RDN, 24'h000000, 8'd255, 4'b1100);
    op("zero_in", 48'h0000_0000_0000, 10'sd5,   1'b1, C_FPU_RM_RNE, 24'h000000, 8'd0,   4'b0001);
`ifdef FPU_NORM_SUBNORM_EN
    op("subn",    48'h1000_0000_0000, 10'sd1,   1'b0, C_FPU_RM_RNE, 24'h200000, 8'd0,   4'b0000);
    op("subn_rs", 48'h4000_0000_0000, -10'sd2,  1'b0, C_FPU_RM_RNE, 24'h100000, 8'd0,   4'b0000);
    op("subn_hb", 48'h3FFF_FFFF_FFFF, 10'sd1,   1'b0, C_FPU_RM_RNE, 24'h800000, 8'd1,   4'b1000);
`else
    op("subn",    48'h1000_0000_0000, 10'sd1,   1'b0, C_FPU_RM_RNE, 24'h000000, 8'd0,   4'b1011);
    op("subn_rs", 48'h4000_0000_0000, -10'sd2,  1'b1, C_FPU_RM_RNE, 24'h000000, 8'd0,   4'b1011);
    op("subn_hb", 48'h3FFF_FFFF_FFFF, 10'sd1,   1'b0, C_FPU_RM_RNE, 24'h000000, 8'd0,   4'b1011);
`endif

    // Backpressure: four back-to-back ops, output stalled for three cycles
    out_ready = 1'b0;
    fork
      begin
        send(48'h4000_0000_0000, 10'sd100, 1'b0, C_FPU_RM_RNE);
        send(48'h4000_0000_0000, 10'sd101, 1'b0, C_FPU_RM_RNE);
        send(48'h4000_0000_0000, 10'sd102, 1'b0, C_FPU_RM_RNE);
        send(48'h4000_0000_0000, 10'sd103, 1'b0, C_FPU_RM_RNE);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready",  48'(in_ready),  48'd0);
        chk("bp_out_valid", 48'(out_valid), 48'd1);
        chk("bp_hold_exp",  48'(exp_res),   48'd100);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++) begin
      get_res("bp", q);
      chk("bp_order", 48'(q.exp), 48'(100 + i));
    end
    @(posedge clk); #1;

    // Flush with two ops in flight
    out_ready = 1'b0;
    send(48'h4000_0000_0000, 10'sd50, 1'b0, C_FPU_RM_RNE);
    send(48'h4000_0000_0000, 10'sd51, 1'b0, C_FPU_RM_RNE);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid",    48'(out_valid), 48'd0);
    chk("fl_in_ready", 48'(in_ready),  48'd1);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= out_valid; end
    chk("fl_quiet", 48'(seen | (outq.size() != 0)), 48'd0);
    @(posedge clk); #1;

    // Input presented during a flush cycle is dropped
    flush = 1'b1; in_valid = 1'b1; mant_in = 48'h4000_0000_0000; exp_in = 10'sd60;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= out_valid; end
    chk("fl_drop", 48'(seen | (outq.size() != 0)), 48'd0);
    @(posedge clk); #1;

    // Reset in the middle of held traffic
    out_ready = 1'b0;
    send(48'h4000_0000_0000, 10'sd70, 1'b1, C_FPU_RM_RNE);
    send(48'h4000_0000_0000, 10'sd71, 1'b1, C_FPU_RM_RNE);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    chk("mrst_valid",    48'(out_valid), 48'd0);
    chk("mrst_data",     48'({mant_res, exp_res, sign_res, nx, of, uf, zr}), 48'd0);
    chk("mrst_in_ready", 48'(in_ready),  48'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
